// File: rtl/ack_bus_rr_scheduler.sv
// Round-robin arbiter for the shared ack bus (mem/sha/aes/ctrl) with a turnaround
// cycle between grants and a watchdog that reclaims the bus from a hung grantee.
module ack_bus_rr_scheduler #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_mem,
  input  logic       req_sha,
  input  logic       req_aes,
  input  logic       req_ctrl,
  input  logic       ack_done,
  output logic       ack_ready_to_mem,
  output logic       ack_ready_to_sha,
  output logic       ack_ready_to_aes,
  output logic       ack_ready_to_ctrl,
  output logic [1:0] winner_source_id,
  output logic       grant_valid,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t               state, state_nxt;
  logic [3:0]           req;
  logic [3:0]           grant, grant_nxt;
  logic [1:0]           id_q, id_nxt;
  logic                 valid_q, valid_nxt;
  logic [1:0]           rr_ptr, rr_ptr_nxt;
  logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
  logic                 tout_q, tout_nxt;
  logic [1:0]           pick_id;
  logic                 pick_ok;
  logic [1:0]           scan_idx;
  logic                 wdog_last;

  assign req       = {req_ctrl, req_aes, req_sha, req_mem};
  assign wdog_last = (wdog == TIMEOUT_W'(TIMEOUT - 1));

  // First asserted request scanning upward from rr_ptr, wrapping mod 4.
  always_comb begin
    pick_ok  = 1'b0;
    pick_id  = rr_ptr;
    scan_idx = rr_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_idx = rr_ptr + 2'(i);
      if (!pick_ok && req[scan_idx]) begin
        pick_ok = 1'b1;
        pick_id = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    id_nxt     = id_q;
    valid_nxt  = valid_q;
    rr_ptr_nxt = rr_ptr;
    wdog_nxt   = wdog;
    tout_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = GRANT;
          grant_nxt = 4'b0001 << pick_id;
          id_nxt    = pick_id;
          valid_nxt = 1'b1;
          wdog_nxt  = '0;
        end
      end
      GRANT: begin
        // id_q holds the winner for the whole grant; ack_done outranks the other exits.
        if (ack_done || !req[id_q] || wdog_last) begin
          state_nxt  = TURN;
          grant_nxt  = '0;
          id_nxt     = 2'b11;
          valid_nxt  = 1'b0;
          rr_ptr_nxt = id_q + 2'd1;
          wdog_nxt   = '0;
          tout_nxt   = !ack_done && req[id_q];
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      TURN: begin
        state_nxt = IDLE;
        wdog_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        id_nxt    = 2'b11;
        valid_nxt = 1'b0;
        wdog_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      id_q    <= 2'b11;
      valid_q <= 1'b0;
      rr_ptr  <= '0;
      wdog    <= '0;
      tout_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      id_q    <= id_nxt;
      valid_q <= valid_nxt;
      rr_ptr  <= rr_ptr_nxt;
      wdog    <= wdog_nxt;
      tout_q  <= tout_nxt;
    end
  end

  assign ack_ready_to_mem  = grant[0];
  assign ack_ready_to_sha  = grant[1];
  assign ack_ready_to_aes  = grant[2];
  assign ack_ready_to_ctrl = grant[3];
  assign winner_source_id  = id_q;
  assign grant_valid       = valid_q;
  assign timeout_err       = tout_q;

endmodule
